// File: rtl/tpu_package.sv
// Shared types and defaults for the TPU datapath blocks.
package tpu_package;

  localparam int TILE_DIM_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_W = 2'd1,
    ST_READ   = 2'd2,
    ST_DONE   = 2'd3
  } ubrs_state_e;

endpackage

// File: rtl/ub_wrap_counter.sv
// Loop counter: load restarts at zero, increment wraps to zero at limit_i,
// tc_o flags that the count currently sits at the limit.
module ub_wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= tc_o ? '0 : count_q + W'(1);
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == limit_i);

endmodule

// File: rtl/unified_buffer_read_sequencer.sv
// Walks the unified buffer in x / pass / y-tile / row order, issuing one read
// per accepted cycle and pausing for a weight tile before every pass.
module unified_buffer_read_sequencer
  import tpu_package::*;
#(
  parameter int ADDR_W   = 12,
  parameter int TILE_DIM = TILE_DIM_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [ADDR_W-1:0]           base_addr_i,
  input  logic [ADDR_W-1:0]           col_stride_i,
  input  logic [CNT_W-1:0]            tiles_y_m1_i,
  input  logic [CNT_W-1:0]            tiles_x_m1_i,
  input  logic [CNT_W-1:0]            reuse_m1_i,
  input  logic [$clog2(TILE_DIM)-1:0] last_rows_m1_i,
  input  logic                        weights_rdy_i,
  input  logic                        rd_ready_i,
  output logic                        rd_valid_o,
  output logic [ADDR_W-1:0]           rd_addr_o,
  output logic                        last_row_o,
  output logic                        last_pass_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int RW = $clog2(TILE_DIM);
  localparam logic [RW-1:0] ROW_MAX = RW'(TILE_DIM - 1);

  ubrs_state_e state_q, state_d;
  logic [ADDR_W-1:0] stride_q, xbase_q, xbase_d, addr_q, addr_d;
  logic [CNT_W-1:0]  ty_q, tx_q, reuse_q;
  logic [RW-1:0]     lr_q;
  logic valid_q, valid_d, last_row_q, last_row_d, last_pass_q, last_pass_d;
  logic pend_q, pend_d, busy_q, done_q;

  logic              latch, fire, pass_end;
  logic              row_tc, y_tc, pass_tc, x_tc;
  logic [RW-1:0]     row_cnt, row_lim, row_nxt;
  logic [CNT_W-1:0]  y_cnt, y_nxt, pass_cnt, x_cnt_unused;

  assign fire     = valid_q & rd_ready_i;
  assign row_lim  = y_tc ? lr_q : ROW_MAX;
  assign pass_end = row_tc & y_tc;

  ub_wrap_counter #(.W(RW)) u_row (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(latch), .inc_i(fire),
    .limit_i(row_lim), .count_o(row_cnt), .tc_o(row_tc)
  );
  ub_wrap_counter #(.W(CNT_W)) u_y (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(latch), .inc_i(fire & row_tc),
    .limit_i(ty_q), .count_o(y_cnt), .tc_o(y_tc)
  );
  ub_wrap_counter #(.W(CNT_W)) u_pass (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(latch), .inc_i(fire & pass_end),
    .limit_i(reuse_q), .count_o(pass_cnt), .tc_o(pass_tc)
  );
  ub_wrap_counter #(.W(CNT_W)) u_x (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(latch), .inc_i(fire & pass_end & pass_tc),
    .limit_i(tx_q), .count_o(x_cnt_unused), .tc_o(x_tc)
  );

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    xbase_d     = xbase_q;
    last_row_d  = last_row_q;
    last_pass_d = last_pass_q;
    pend_d      = pend_q;
    latch       = 1'b0;
    // Row/y indices of the read that follows the current one within a pass.
    row_nxt     = row_tc ? '0 : row_cnt + RW'(1);
    y_nxt       = row_tc ? y_cnt + CNT_W'(1) : y_cnt;
    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (start_i || pend_q) begin
          latch   = 1'b1;
          xbase_d = base_addr_i;
          state_d = ST_WAIT_W;
        end
      end
      ST_WAIT_W: begin
        if (weights_rdy_i) begin
          state_d     = ST_READ;
          valid_d     = 1'b1;
          addr_d      = xbase_q;
          last_row_d  = (ty_q == '0) && (lr_q == '0);
          last_pass_d = (pass_cnt == reuse_q);
        end
      end
      ST_READ: begin
        if (fire) begin
          if (pass_end) begin
            valid_d = 1'b0;
            state_d = (pass_tc && x_tc) ? ST_DONE : ST_WAIT_W;
            if (pass_tc) xbase_d = xbase_q + stride_q;
          end else begin
            // Consecutive y tiles are contiguous, so the address just steps by one.
            addr_d     = addr_q + ADDR_W'(1);
            last_row_d = (row_nxt == ((y_nxt == ty_q) ? lr_q : ROW_MAX));
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        pend_d  = start_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      xbase_q     <= '0;
      last_row_q  <= 1'b0;
      last_pass_q <= 1'b0;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stride_q    <= '0;
      ty_q        <= '0;
      tx_q        <= '0;
      reuse_q     <= '0;
      lr_q        <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      xbase_q     <= xbase_d;
      last_row_q  <= last_row_d;
      last_pass_q <= last_pass_d;
      pend_q      <= pend_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      if (latch) begin
        stride_q <= col_stride_i;
        ty_q     <= tiles_y_m1_i;
        tx_q     <= tiles_x_m1_i;
        reuse_q  <= reuse_m1_i;
        lr_q     <= last_rows_m1_i;
      end
    end
  end

  assign rd_valid_o  = valid_q;
  assign rd_addr_o   = addr_q;
  assign last_row_o  = last_row_q;
  assign last_pass_o = last_pass_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_unified_buffer_read_sequencer.sv
// Randomized bench: each job's read stream is compared with a nested-loop
// reference model; handshake holds, weight gating and done/idle are checked.
module tb_unified_buffer_read_sequencer;

  localparam int TD     = 32;
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic [11:0] base;
    logic [11:0] stride;
    logic [7:0]  ty;
    logic [7:0]  tx;
    logic [7:0]  reuse;
    logic [4:0]  lr;
  } cfg_t;

  typedef struct packed {
    logic [11:0] addr;
    logic        lrow;
    logic        lpass;
    logic        pend;
  } rd_t;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, weights_rdy_i, rd_ready_i;
  logic [11:0] base_addr_i, col_stride_i, rd_addr_o;
  logic [7:0]  tiles_y_m1_i, tiles_x_m1_i, reuse_m1_i;
  logic [4:0]  last_rows_m1_i;
  logic        rd_valid_o, last_row_o, last_pass_o, busy_o, done_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  rd_t  exp_q[$];
  cfg_t c, c2;

  always #5 clk_i = ~clk_i;

  unified_buffer_read_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .col_stride_i(col_stride_i),
    .tiles_y_m1_i(tiles_y_m1_i), .tiles_x_m1_i(tiles_x_m1_i),
    .reuse_m1_i(reuse_m1_i), .last_rows_m1_i(last_rows_m1_i),
    .weights_rdy_i(weights_rdy_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o), .rd_addr_o(rd_addr_o),
    .last_row_o(last_row_o), .last_pass_o(last_pass_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic cfg_t mk(input logic [11:0] b, input logic [11:0] s, input logic [7:0] ty,
                              input logic [7:0] tx, input logic [7:0] r, input logic [4:0] lr);
    cfg_t k;
    k.base = b; k.stride = s; k.ty = ty; k.tx = tx; k.reuse = r; k.lr = lr;
    return k;
  endfunction

  // Reference: plain nested loops over x, pass, y tile, row.
  function automatic void build_model(input cfg_t k);
    rd_t e;
    int  nrows;
    exp_q.delete();
    for (int x = 0; x <= int'(k.tx); x++)
      for (int p = 0; p <= int'(k.reuse); p++)
        for (int y = 0; y <= int'(k.ty); y++) begin
          nrows = (y == int'(k.ty)) ? int'(k.lr) + 1 : TD;
          for (int r = 0; r < nrows; r++) begin
            e.addr  = 12'(int'(k.base) + x * int'(k.stride) + y * TD + r);
            e.lrow  = (r == nrows - 1);
            e.lpass = (p == int'(k.reuse));
            e.pend  = (y == int'(k.ty)) && (r == nrows - 1);
            exp_q.push_back(e);
          end
        end
  endfunction

  task automatic drive_cfg(input cfg_t k);
    base_addr_i = k.base; col_stride_i = k.stride;
    tiles_y_m1_i = k.ty; tiles_x_m1_i = k.tx; reuse_m1_i = k.reuse; last_rows_m1_i = k.lr;
  endtask

  task automatic scramble_cfg();
    base_addr_i    = 12'($urandom);
    col_stride_i   = 12'($urandom);
    tiles_y_m1_i   = 8'($urandom);
    tiles_x_m1_i   = 8'($urandom);
    reuse_m1_i     = 8'($urandom);
    last_rows_m1_i = 5'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after it latched.
  task automatic start_job(input cfg_t k);
    drive_cfg(k);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    scramble_cfg();
  endtask

  task automatic run_job(input string name, input cfg_t k, input int rdy_pct,
                         input int abort_after, input bit chain, input cfg_t kn);
    rd_t        e;
    int         total, acc, cyc, wlow;
    bit         rdy, w, fire, p_valid, p_rdy, p_wait, p_w, finished;
    logic [13:0] p_out;
    build_model(k);
    total = exp_q.size();
    acc = 0; cyc = 0; wlow = $urandom_range(0, 2);
    p_valid = 0; p_rdy = 0; p_wait = 0; p_w = 0; p_out = '0; finished = 0;
    while (!finished) begin
      if (p_wait) check({name, ":wait_gate"}, 32'(rd_valid_o), 32'(p_w));
      if (p_valid && !p_rdy)
        check({name, ":hold"}, 32'({rd_valid_o, rd_addr_o, last_row_o, last_pass_o}), 32'({1'b1, p_out}));
      if (abort_after > 0 && acc == abort_after) begin
        rst_i = 1'b1; rd_ready_i = 1'b0; weights_rdy_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check({name, ":reset_outs"},
              32'({rd_valid_o, rd_addr_o, last_row_o, last_pass_o, busy_o, done_o}), 32'd0);
        rst_i = 1'b0;
        repeat (3) begin
          @(negedge clk_i);
          check({name, ":post_reset_idle"}, 32'({busy_o, done_o, rd_valid_o}), 32'd0);
        end
        finished = 1;
      end else if (done_o) begin
        check({name, ":done_after_last"}, exp_q.size(), 32'd0);
        check({name, ":read_count"}, acc, total);
        if (chain) begin
          drive_cfg(kn);
          start_i = 1'b1;
        end else begin
          start_i = 1'b0;
        end
        rd_ready_i = 1'($urandom_range(0, 1));
        weights_rdy_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        check({name, ":idle_after_done"}, 32'({busy_o, done_o, rd_valid_o}), 32'd0);
        start_i = 1'b0;
        if (chain) begin
          @(negedge clk_i);
          scramble_cfg();
        end
        finished = 1;
      end else if (cyc > BUDGET) begin
        check({name, ":timeout_done"}, 32'(done_o), 32'd1);
        finished = 1;
      end else begin
        rdy  = ($urandom_range(0, 99) < rdy_pct);
        fire = rd_valid_o && rdy;
        if (fire) begin
          if (exp_q.size() == 0) begin
            check({name, ":no_more_reads"}, 32'(rd_valid_o), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check({name, ":addr"}, 32'(rd_addr_o), 32'(e.addr));
            check({name, ":last_row"}, 32'(last_row_o), 32'(e.lrow));
            check({name, ":last_pass"}, 32'(last_pass_o), 32'(e.lpass));
            acc++;
            if (e.pend) wlow = $urandom_range(2, 4);
          end
        end
        if (wlow > 0) begin
          w = 1'b0;
          wlow--;
        end else begin
          w = ($urandom_range(0, 2) != 0);
        end
        p_wait  = busy_o && !rd_valid_o;
        p_valid = rd_valid_o;
        p_rdy   = rdy;
        p_w     = w;
        p_out   = {rd_addr_o, last_row_o, last_pass_o};
        rd_ready_i    = rdy;
        weights_rdy_i = w;
        start_i       = busy_o ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc++;
        @(negedge clk_i);
      end
    end
    $display("job %-12s base=%03h stride=%03h ty=%0d tx=%0d reuse=%0d lr=%0d reads=%0d/%0d",
             name, k.base, k.stride, k.ty, k.tx, k.reuse, k.lr, acc, total);
    exp_q.delete();
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; weights_rdy_i = 1'b0; rd_ready_i = 1'b0;
    scramble_cfg();
    repeat (3) @(negedge clk_i);
    check("rst:valid", 32'(rd_valid_o), 32'd0);
    check("rst:addr", 32'(rd_addr_o), 32'd0);
    check("rst:last_row", 32'(last_row_o), 32'd0);
    check("rst:last_pass", 32'(last_pass_o), 32'd0);
    check("rst:busy", 32'(busy_o), 32'd0);
    check("rst:done", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle:busy", 32'(busy_o), 32'd0);

    c = mk(12'h010, 12'h040, 8'd1, 8'd1, 8'd0, 5'd31);
    start_job(c); run_job("tiles2x2", c, 100, 0, 1'b0, c);

    c = mk(12'($urandom), 12'($urandom), 8'd0, 8'd0, 8'd2, 5'd31);
    start_job(c); run_job("reuse3", c, 100, 0, 1'b0, c);

    c = mk(12'h010, 12'h040, 8'd1, 8'd1, 8'd0, 5'd31);
    start_job(c); run_job("rdy_random", c, 50, 0, 1'b0, c);

    c = mk(12'($urandom), 12'($urandom), 8'd1, 8'd0, 8'd0, 5'd4);
    start_job(c); run_job("short_tail", c, 70, 0, 1'b0, c);

    c = mk(12'hFF0, 12'($urandom), 8'd0, 8'd0, 8'd0, 5'd31);
    start_job(c); run_job("addr_wrap", c, 80, 0, 1'b0, c);

    c = mk(12'($urandom), 12'($urandom), 8'd0, 8'd0, 8'd0, 5'd0);
    start_job(c); run_job("single", c, 60, 0, 1'b0, c);

    c = mk(12'($urandom), 12'($urandom), 8'd1, 8'd1, 8'd1, 5'd31);
    start_job(c); run_job("abort", c, 80, 10, 1'b0, c);
    c = mk(12'($urandom), 12'($urandom), 8'd1, 8'd1, 8'd0, 5'd7);
    start_job(c); run_job("after_abort", c, 80, 0, 1'b0, c);

    c  = mk(12'($urandom), 12'($urandom), 8'd0, 8'd1, 8'd1, 5'd9);
    c2 = mk(12'($urandom), 12'($urandom), 8'd1, 8'd0, 8'd1, 5'd3);
    start_job(c); run_job("chain_a", c, 80, 0, 1'b1, c2);
    run_job("chain_b", c2, 80, 0, 1'b0, c2);

    for (int k = 0; k < 6; k++) begin
      c = mk(12'($urandom), 12'($urandom), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)),
             8'($urandom_range(0, 2)), 5'($urandom));
      start_job(c);
      run_job("random", c, $urandom_range(40, 100), 0, 1'b0, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
